// File: rtl/mem_access_ctrl.sv
// Memory-access sequencer in front of a synchronous single-port RAM.
// Accepts a single-word write or a burst read and runs it one RAM operation at a time.
module mem_access_ctrl #(
    parameter int AW = 12,
    parameter int DW = 16,
    parameter int LW = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic          rvalid,
    output logic [DW-1:0] rdata,
    output logic          overrun,
    output logic          ram_read,
    output logic          ram_write,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t        state_q;
    logic [AW-1:0] ar_q;
    logic [DW-1:0] wbuf_q;
    logic [DW-1:0] dr_q;
    logic [LW-1:0] cnt_q;
    logic          op_q;
    logic          busy_q;
    logic          done_q;
    logic          rvalid_q;
    logic          overrun_q;
    logic          rd_q;
    logic          wr_q;
    logic [AW-1:0] ar_d;

    // Next burst address; wraps naturally at the top of the address space.
    assign ar_d = ar_q + AW'(1);

    // Strobes are registered alongside the state transition, so they are high
    // exactly while the FSM sits in ISSUE and are cleared by reset at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            ar_q      <= '0;
            wbuf_q    <= '0;
            dr_q      <= '0;
            cnt_q     <= '0;
            op_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            if (req && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        ar_q    <= addr;
                        wbuf_q  <= wdata;
                        op_q    <= we;
                        cnt_q   <= len;
                        wr_q    <= we;
                        rd_q    <= ~we;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (op_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    dr_q     <= ram_rdata;
                    rvalid_q <= 1'b1;
                    if (cnt_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= cnt_q - LW'(1);
                        ar_q    <= ar_d;
                        rd_q    <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rvalid    = rvalid_q;
    assign rdata     = dr_q;
    assign overrun   = overrun_q;
    assign ram_read  = rd_q;
    assign ram_write = wr_q;
    assign ram_addr  = ar_q;
    assign ram_wdata = wbuf_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural sync RAM, scenario tasks, and a
// queue of expected read data consumed on every rvalid beat.
module tb_mem_access_ctrl;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int LW = 4;

    logic          CLK   = 1'b0;
    logic          RST_N = 1'b0;
    logic          req   = 1'b0;
    logic          we    = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [LW-1:0] len   = '0;
    logic [DW-1:0] wdata = '0;
    logic          busy, done, rvalid, overrun, ram_read, ram_write;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] mem [0:4095];
    logic          pl_en   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] addr_seen [$];
    int st_cycles, st_rv, st_dn, st_wr;
    bit st_gap_bad, st_done_rv;

    mem_access_ctrl #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .CLK(CLK), .RST_N(RST_N), .req(req), .we(we), .addr(addr), .len(len),
        .wdata(wdata), .busy(busy), .done(done), .rvalid(rvalid), .rdata(rdata),
        .overrun(overrun), .ram_read(ram_read), .ram_write(ram_write),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_write) mem[ram_addr] <= ram_wdata;
        if (ram_read) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge CLK);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(negedge CLK);
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l,
                         input logic [DW-1:0] d);
        @(negedge CLK);
        req = 1'b1; we = w; addr = a; len = l; wdata = d;
        @(posedge CLK); #1;
        req = 1'b0;
        $display("txn we=%0b addr=%h len=%0d wdata=%h", w, a, l, d);
    endtask

    // Runs from the first ISSUE cycle until busy falls, popping the expected queue on each rvalid.
    task automatic run_to_idle(input int inj_at);
        int last_rv;
        logic [DW-1:0] e;
        last_rv = -1;
        st_cycles = 0; st_rv = 0; st_dn = 0; st_wr = 0;
        st_gap_bad = 1'b0; st_done_rv = 1'b0;
        addr_seen.delete();
        while (busy && st_cycles < 200) begin
            if (st_cycles == inj_at) begin
                req = 1'b1; we = 1'b1; addr = 12'h300; wdata = 16'h5555;
            end else if (st_cycles == inj_at + 1) begin
                req = 1'b0;
            end
            st_cycles++;
            if (rvalid) begin
                st_rv++;
                if (last_rv >= 0 && st_cycles - last_rv != 2) st_gap_bad = 1'b1;
                last_rv = st_cycles;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid_unexpected: got rdata %h expected no beat", rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (rdata !== e) begin
                        errors++;
                        $display("FAIL rdata_beat%0d: got %h expected %h", st_rv, rdata, e);
                    end
                end
                $display("beat %0d rdata=%h", st_rv, rdata);
            end
            if (done) begin
                st_dn++;
                st_done_rv = rvalid;
            end
            if (ram_write) st_wr++;
            if (ram_read) addr_seen.push_back(ram_addr);
            @(posedge CLK); #1;
        end
        req = 1'b0;
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL busy_timeout: got busy=1 expected 0 within 200 cycles");
        end
    endtask

    task automatic test_reset();
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_strobes", {ram_read, ram_write}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_write_read();
        issue(1'b1, 12'h123, 4'd0, 16'hBEEF);
        chk("wr_strobe", {ram_write, ram_read}, 2'b10);
        chk("wr_addr", ram_addr, 12'h123);
        chk("wr_wdata", ram_wdata, 16'hBEEF);
        chk("wr_done_early", done, 0);
        @(posedge CLK); #1;
        chk("wr_done", done, 1);
        chk("wr_strobe_off", ram_write, 0);
        @(posedge CLK); #1;
        chk("wr_idle", busy, 0);
        chk("wr_mem", mem[12'h123], 16'hBEEF);
        exp_q.push_back(16'hBEEF);
        issue(1'b0, 12'h123, 4'd0, 16'h0000);
        run_to_idle(-1);
        chk("rd1_busy_cycles", st_cycles, 3);
        chk("rd1_beats", st_rv, 1);
        chk("rd1_done_with_rvalid", {st_dn[0], st_done_rv}, 2'b11);
        chk("rd1_rdata_hold", rdata, 16'hBEEF);
    endtask

    task automatic test_burst();
        for (int i = 0; i < 4; i++) preload(12'h040 + 12'(i), 16'(i + 1));
        for (int i = 0; i < 4; i++) exp_q.push_back(16'(i + 1));
        issue(1'b0, 12'h040, 4'd3, 16'h0000);
        run_to_idle(-1);
        chk("burst_busy_cycles", st_cycles, 9);
        chk("burst_beats", st_rv, 4);
        chk("burst_gap", st_gap_bad, 0);
        chk("burst_done", {st_dn[0], st_done_rv}, 2'b11);
        chk("burst_no_write", st_wr, 0);
        chk("burst_queue_empty", exp_q.size(), 0);
    endtask

    task automatic test_wrap();
        preload(12'hFFE, 16'hAAAA);
        preload(12'hFFF, 16'hBBBB);
        preload(12'h000, 16'hCCCC);
        exp_q.push_back(16'hAAAA); exp_q.push_back(16'hBBBB); exp_q.push_back(16'hCCCC);
        issue(1'b0, 12'hFFE, 4'd2, 16'h0000);
        run_to_idle(-1);
        chk("wrap_beats", st_rv, 3);
        chk("wrap_naddr", addr_seen.size(), 3);
        if (addr_seen.size() == 3) begin
            chk("wrap_addr0", addr_seen[0], 12'hFFE);
            chk("wrap_addr1", addr_seen[1], 12'hFFF);
            chk("wrap_addr2", addr_seen[2], 12'h000);
        end
    endtask

    task automatic test_overrun();
        preload(12'h300, 16'h1234);
        for (int i = 0; i < 16; i++) preload(12'h200 + 12'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 16; i++) exp_q.push_back(16'h1000 + 16'(i));
        chk("ovr_clear_before", overrun, 0);
        issue(1'b0, 12'h200, 4'd15, 16'h0000);
        run_to_idle(4);
        chk("ovr_busy_cycles", st_cycles, 33);
        chk("ovr_beats", st_rv, 16);
        chk("ovr_no_write", st_wr, 0);
        chk("ovr_mem_unchanged", mem[12'h300], 16'h1234);
        chk("ovr_flag", overrun, 1);
    endtask

    task automatic test_input_change();
        issue(1'b1, 12'h0AB, 4'd0, 16'h7777);
        addr = 12'h555; wdata = 16'h0000;
        chk("chg_wr_addr", ram_addr, 12'h0AB);
        chk("chg_wr_wdata", ram_wdata, 16'h7777);
        run_to_idle(-1);
        chk("chg_mem", mem[12'h0AB], 16'h7777);
        chk("chg_wbuf_hold", ram_wdata, 16'h7777);
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0002);
        issue(1'b0, 12'h040, 4'd1, 16'h0000);
        len = 4'd15; addr = 12'h300;
        run_to_idle(-1);
        chk("chg_rd_beats", st_rv, 2);
        chk("chg_rd_cycles", st_cycles, 5);
        chk("chg_overrun_sticky", overrun, 1);
    endtask

    task automatic test_reset_mid_burst();
        int dn;
        issue(1'b0, 12'h040, 4'd3, 16'h0000);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("mid_issue2_read", ram_read, 1);
        chk("mid_beat1", {rvalid, rdata}, {1'b1, 16'h0001});
        RST_N = 1'b0;
        #1;
        chk("mid_read_drop", ram_read, 0);
        chk("mid_busy", busy, 0);
        chk("mid_rdata", rdata, 0);
        chk("mid_overrun", overrun, 0);
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            if (done || rvalid) dn++;
        end
        chk("mid_no_done", dn, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        preload(12'h010, 16'h0F0F);
        exp_q.push_back(16'h0F0F);
        issue(1'b0, 12'h010, 4'd0, 16'h0000);
        run_to_idle(-1);
        chk("post_rst_cycles", st_cycles, 3);
        chk("post_rst_beats", {st_rv[3:0], st_dn[3:0]}, 8'h11);
        chk("post_rst_rdata", rdata, 16'h0F0F);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_burst();
        test_wrap();
        test_overrun();
        test_input_change();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
